i2c_cfg_master: RTL and testbench
=================================

Name: i2c_cfg_master

Overview:
- Single-clock I2C write master; the link-level partner of the codec init sequencer.
- Accepts a 24-bit word {device address+W, register byte, data byte} with a GO request.
- Serialises the word onto SCLK/SDAT as an I2C write with START, 3×(8 data + ACK) bits and STOP.
- Returns END (transfer done) and ACK status. Sits between the WM8731 configuration ROM and the board I2C pins.

Parameters:
- DIV, 125: CLOCK cycles per quarter-bit tick. 50 MHz/(4×125) gives 100 kHz SCLK. Legal range 2..1023.
- NBYTES, 3: bytes per transfer. Fixed at 3 for the WM8731; bit counters sized for up to 4.

Ports:
- CLOCK  in  1  system clock, 50 MHz
- RESET  in  1  asynchronous, active-low reset
- GO  in  1  transfer request; level signal, start triggered on its 0→1 transition
- DATA  in  24  transfer word; DATA[23:16] sent first, MSB-first
- END  out  1  low while busy; high when idle/done
- ACK  out  3  per-byte ACK seen (1 = slave pulled SDAT low), byte0 = bit2
- ACK_ERR  out  1  OR of missing ACKs in the last transfer
- SCLK  out  1  I2C clock, push-pull
- SDAT_OE  out  1  1 = drive SDAT low; 0 = release (open-drain emulation)
- SDAT_IN  in  1  sampled pad value of SDAT, already synchronised externally

Behaviour:
- Reset (RESET=0, async) values: SCLK=1, SDAT_OE=0, END=0, ACK=3'b000, ACK_ERR=0, state=IDLE, go_d=0, tick counter=0.
- END=0 at reset: an upstream sequencer holding GO high starts the first transfer immediately after reset release.
- Tick generator: free-running counter 0..DIV-1; tick pulses 1 cycle at count DIV-1. Counter is cleared on leaving IDLE so timing is aligned to the start.
- GO edge: go_d registers GO. A start occurs in IDLE when GO=1 and go_d=0. On start:
  - latch DATA into shift register;
  - clear ACK and ACK_ERR;
  - END←0.
  - GO and DATA are ignored while busy.
- States: IDLE → START → BIT → ACKB → (BIT | STOP) → DONE → IDLE. Each non-IDLE state advances a 2-bit phase on every tick.
  - START, SCLK high: ph0 SDA released; ph1 SDA low; ph2 SDA low; ph3 SCLK low.
  - BIT: ph0 drive SDAT_OE=~shift[23], SCLK low; ph1 SCLK high; ph2 SCLK high; ph3 SCLK low, then shift left by 1. After 8 bits go to ACKB.
  - ACKB: SDAT_OE=0. Sample SDAT_IN at ph2; ACK[byte] ← ~SDAT_IN. After ph3: if the byte was the last, go to STOP, otherwise BIT.
  - STOP: ph0 SDA low, SCLK low; ph1 SCLK high; ph2 SDA released; ph3 hold. Then DONE.
  - DONE: one CLOCK cycle. END←1, ACK_ERR←~&ACK. Then IDLE.
- Timing: 4 + 27×4 + 4 = 116 ticks. END rises exactly 116×DIV+2 CLOCK cycles after the cycle GO is first sampled high.
- SDAT changes only while SCLK is low, except for START and STOP.
- END holds high until the next start, ready for an upstream posedge-END counter.
- ACK/ACK_ERR are stable from DONE until the next start.
- RESET asserted mid-transfer: immediate return to reset values. The bus is released with SCLK=1 and SDAT_OE=0; no STOP is generated.
- GO falling then rising within a transfer: ignored. A rising edge during DONE is also ignored, since go_d tracks GO continuously.

Optional Feature:
- Macro I2C_CFG_NACK_ABORT_EN.
- Defined: a missing ACK at ACKB ph2 jumps straight to STOP after ph3. Remaining bytes are skipped, their ACK bits stay 0, ACK_ERR=1. END rises earlier: (4+9×k×4+4)×DIV+2 cycles, k = bytes sent.
- Undefined: all 3 bytes are always sent; NACK is only reported.

Decomposition:
- Package i2c_cfg_pkg:
  - state enum {IDLE, START, BIT, ACKB, STOP, DONE};
  - phase constants PH0..PH3;
  - WM8731_ADDR_W = 8'h34;
  - BITS_PER_TICKFRAME = 4.
- Sub-module i2c_tick_gen (parameter DIV; ports CLOCK, RESET, clr, tick), instantiated once.

Test Plan:
- Reset, DIV=4, slave model ACKs, GO 0→1 with DATA=24'h340C00 → SCLK shows 27 high pulses; decoded bytes 34,0C,00; END rises 466 cycles after GO sampled; ACK=3'b111, ACK_ERR=0.
- GO held 1 across reset release, DATA=24'h341201 → transfer starts without a toggle; END 0→1 once; no second transfer until GO drops and rises.
- Slave NACKs the 2nd byte, DATA=24'h340E5B, macro off → all 3 bytes sent; ACK=3'b101, ACK_ERR=1. Macro on → STOP after byte 2; ACK=3'b100; END at (4+72+4)×4+2 = 322 cycles.
- RESET pulsed low at tick 40 of a transfer → next edge: SCLK=1, SDAT_OE=0, END=0. A new GO edge then completes a clean transfer.
- GO toggled and DATA changed mid-transfer → the wire carries only the original word; exactly one END rise.
- Protocol monitor over 9 back-to-back transfers driven by an 8-entry-plus-1 ROM sequencer model: SDAT never changes while SCLK=1 except at START/STOP; 9 END rising edges.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration write master.
// The optional early-abort-on-NACK behaviour is selected in i2c_cfg_master
// with the macro I2C_CFG_NACK_ABORT_EN.
package i2c_cfg_pkg;

    // Transfer sequencing states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BIT   = 3'd2,
        ACKB  = 3'd3,
        STOP  = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Quarter-bit phases inside every bit frame.
    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;

    // WM8731 7-bit address 0x1A with the write bit appended.
    localparam logic [7:0] WM8731_ADDR_W = 8'h34;

    // Number of ticks that make up one SCLK bit period.
    localparam int BITS_PER_TICKFRAME = 4;

    // Bus levels for a given state/phase: returns {sclk, sdat_oe}.
    // bit_v is the data bit currently being presented on SDAT.
    function automatic logic [1:0] bus_drive(input state_e st,
                                             input logic [1:0] ph,
                                             input logic bit_v);
        logic [1:0] drv;
        drv = 2'b10;
        case (st)
            START: begin
                case (ph)
                    PH0:     drv = 2'b10;
                    PH1:     drv = 2'b11;
                    PH2:     drv = 2'b11;
                    default: drv = 2'b01;
                endcase
            end
            BIT:  drv = {((ph == PH1) || (ph == PH2)), ~bit_v};
            ACKB: drv = {((ph == PH1) || (ph == PH2)), 1'b0};
            STOP: begin
                case (ph)
                    PH0:     drv = 2'b01;
                    PH1:     drv = 2'b11;
                    default: drv = 2'b10;
                endcase
            end
            default: drv = 2'b10;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/i2c_cfg_master_tick_gen.sv
// Quarter-bit tick generator: a free-running 0..DIV-1 counter whose tick
// output is high for one cycle while the count sits at DIV-1. clr restarts
// the count so the first tick of a transfer lands DIV cycles after start.
module i2c_tick_gen
    import i2c_cfg_pkg::*;
#(
    parameter int DIV = 125
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic clr,
    output logic tick
);

    localparam logic [9:0] LAST = 10'(DIV - 1);

    logic [9:0] cnt_q;
    logic [9:0] cnt_d;
    logic       tick_q;

    // Next count: restart on clr, wrap at DIV-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 10'd0;
        end else if (cnt_q == LAST) begin
            cnt_d = 10'd0;
        end else begin
            cnt_d = cnt_q + 10'd1;
        end
    end

    // Count register and registered tick (high while count == DIV-1).
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            cnt_q  <= 10'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/i2c_cfg_master.sv
// I2C write master for codec configuration: sends a 24-bit word as
// START, three (8 data + ACK) bit frames and STOP, then raises END.
// Optional macro I2C_CFG_NACK_ABORT_EN: a missing ACK ends the transfer
// with STOP right after that byte's ACK slot.
module i2c_cfg_master
    import i2c_cfg_pkg::*;
#(
    parameter int DIV    = 125,
    parameter int NBYTES = 3
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        GO,
    input  logic [23:0] DATA,
    output logic        END,
    output logic [2:0]  ACK,
    output logic        ACK_ERR,
    output logic        SCLK,
    output logic        SDAT_OE,
    input  logic        SDAT_IN
);

    localparam logic [1:0] LAST_BYTE = 2'(NBYTES - 1);

    state_e      state_q, state_d;
    logic [1:0]  ph_q, ph_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [2:0]  ack_q, ack_d;
    logic        ack_err_q, ack_err_d;
    logic        end_q, end_d;
    logic        go_prev_q;
    logic        sclk_q;
    logic        sdat_oe_q;

    logic        tick_s;
    logic        clr_s;
    logic        start_s;
    logic [1:0]  ack_idx_s;
    logic [1:0]  drive_s;

    i2c_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    // A start needs a fresh 0->1 on GO while idle.
    assign start_s   = (state_q == IDLE) && GO && !go_prev_q;
    // Byte 0 reports in ACK[2], the last byte in ACK[0].
    assign ack_idx_s = LAST_BYTE - byte_cnt_q;

    // Next-state logic: phases advance on ticks, counters track bits/bytes.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        ack_d      = ack_q;
        ack_err_d  = ack_err_q;
        end_d      = end_q;
        clr_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d    = START;
                    ph_d       = PH0;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 2'd0;
                    shift_d    = DATA;
                    ack_d      = 3'b000;
                    ack_err_d  = 1'b0;
                    end_d      = 1'b0;
                    clr_s      = 1'b1;
                end else begin
                    ph_d = PH0;
                end
            end
            START: begin
                if (tick_s) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == PH3) begin
                        state_d    = BIT;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 2'd0;
                    end else begin
                        state_d = START;
                    end
                end else begin
                    ph_d = ph_q;
                end
            end
            BIT: begin
                if (tick_s) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == PH3) begin
                        shift_d = {shift_q[22:0], 1'b0};
                        if (bit_cnt_q == 3'd7) begin
                            state_d   = ACKB;
                            bit_cnt_d = 3'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end else begin
                    ph_d = ph_q;
                end
            end
            ACKB: begin
                if (tick_s) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == PH2) begin
                        ack_d[ack_idx_s] = ~SDAT_IN;
                    end else if (ph_q == PH3) begin
`ifdef I2C_CFG_NACK_ABORT_EN
                        if ((byte_cnt_q == LAST_BYTE) || !ack_q[ack_idx_s]) begin
`else
                        if (byte_cnt_q == LAST_BYTE) begin
`endif
                            state_d = STOP;
                        end else begin
                            state_d    = BIT;
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end else begin
                        ack_d = ack_q;
                    end
                end else begin
                    ph_d = ph_q;
                end
            end
            STOP: begin
                if (tick_s) begin
                    ph_d = ph_q + 2'd1;
                    if (ph_q == PH3) begin
                        state_d = DONE;
                    end else begin
                        state_d = STOP;
                    end
                end else begin
                    ph_d = ph_q;
                end
            end
            DONE: begin
                state_d   = IDLE;
                ph_d      = PH0;
                end_d     = 1'b1;
                ack_err_d = ~&ack_q;
            end
            default: begin
                state_d = IDLE;
                ph_d    = PH0;
            end
        endcase
    end

    // Bus levels are derived from the next state so SCLK/SDAT_OE flip on
    // the same edge as the phase they belong to.
    assign drive_s = bus_drive(state_d, ph_d, shift_d[23]);

    // State, datapath and registered pin drivers.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= IDLE;
            ph_q       <= PH0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            shift_q    <= 24'd0;
            ack_q      <= 3'b000;
            ack_err_q  <= 1'b0;
            end_q      <= 1'b0;
            go_prev_q  <= 1'b0;
            sclk_q     <= 1'b1;
            sdat_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            ack_q      <= ack_d;
            ack_err_q  <= ack_err_d;
            end_q      <= end_d;
            go_prev_q  <= GO;
            sclk_q     <= drive_s[1];
            sdat_oe_q  <= drive_s[0];
        end
    end

    assign END     = end_q;
    assign ACK     = ack_q;
    assign ACK_ERR = ack_err_q;
    assign SCLK    = sclk_q;
    assign SDAT_OE = sdat_oe_q;

endmodule

// File: tb/tb_i2c_cfg_master.sv
// Self-checking bench for i2c_cfg_master with an ACKing slave model,
// a bus monitor that decodes bytes, and a byte scoreboard.
module tb_i2c_cfg_master;
    import i2c_cfg_pkg::*;

    localparam int DIV      = 4;
    localparam int XFER_CYC = (BITS_PER_TICKFRAME * (1 + 27 + 1)) * DIV + 2;
    localparam int ABRT_CYC = (BITS_PER_TICKFRAME * (1 + 9 * 2 + 1)) * DIV + 2;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        GO    = 1'b0;
    logic [23:0] DATA  = 24'd0;
    logic        END;
    logic [2:0]  ACK;
    logic        ACK_ERR;
    logic        SCLK;
    logic        SDAT_OE;
    logic        SDAT_IN;
    logic        bus_sda;

    int checks = 0;
    int errors = 0;

    // Monitor / slave state
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_end = 1'b0;
    logic       in_xfer = 1'b0, had_rise = 1'b0, slave_pull = 1'b0;
    logic       mon_clr = 1'b1;
    logic [2:0] ack_mask = 3'b111;
    logic [7:0] cur = 8'd0;
    int         bit_idx = 0, pulses = 0, stops = 0, proto_err = 0, end_rises = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    i2c_cfg_master #(.DIV(DIV), .NBYTES(3)) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .GO      (GO),
        .DATA    (DATA),
        .END     (END),
        .ACK     (ACK),
        .ACK_ERR (ACK_ERR),
        .SCLK    (SCLK),
        .SDAT_OE (SDAT_OE),
        .SDAT_IN (SDAT_IN)
    );

    always #5 CLOCK = ~CLOCK;

    assign bus_sda = ~SDAT_OE & ~slave_pull;
    assign SDAT_IN = bus_sda;

    // Bus monitor and slave: decode bytes, ACK per mask, police SDA changes.
    always @(negedge CLOCK) begin
        if (mon_clr) begin
            in_xfer    <= 1'b0;
            had_rise   <= 1'b0;
            slave_pull <= 1'b0;
            bit_idx    <= 0;
            got_q.delete();
        end else if (prev_scl && SCLK && prev_sda && !bus_sda) begin
            if (in_xfer) proto_err <= proto_err + 1;
            in_xfer  <= 1'b1;
            had_rise <= 1'b0;
            bit_idx  <= 0;
        end else if (prev_scl && SCLK && !prev_sda && bus_sda) begin
            if (!in_xfer || (bit_idx % 9) != 0 || bit_idx == 0) proto_err <= proto_err + 1;
            in_xfer <= 1'b0;
            stops   <= stops + 1;
        end else if (!prev_scl && SCLK) begin
            if (!in_xfer) proto_err <= proto_err + 1;
            had_rise <= 1'b1;
            if ((bit_idx % 9) < 8) cur <= {cur[6:0], bus_sda};
        end else if (prev_scl && !SCLK) begin
            if (had_rise) begin
                had_rise <= 1'b0;
                pulses   <= pulses + 1;
                bit_idx  <= bit_idx + 1;
                if ((bit_idx % 9) == 7) got_q.push_back(cur);
                slave_pull <= ((bit_idx + 1) % 9 == 8) && ((bit_idx + 1) < 27)
                              && ack_mask[2 - (bit_idx + 1) / 9];
            end else begin
                slave_pull <= 1'b0;
            end
        end
        prev_scl <= SCLK;
        prev_sda <= bus_sda;
        prev_end <= END;
        if (END && !prev_end) end_rises <= end_rises + 1;
    end

    // Runs one transfer and counts posedges from GO until END is seen high.
    task automatic do_xfer(input logic [23:0] d, input logic [2:0] mask,
                           input bit toggle, output int cyc);
        @(negedge CLOCK);
        GO = 1'b0;
        repeat (2) @(negedge CLOCK);
        DATA     = d;
        ack_mask = mask;
        GO       = 1'b1;
        cyc      = 0;
        while (cyc < 3000) begin
            @(posedge CLOCK);
            #1;
            cyc++;
            if (toggle && cyc == 100) begin
                GO   = 1'b0;
                DATA = 24'hFFFFFF;
            end
            if (toggle && cyc == 150) GO = 1'b1;
            if (END === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        #2 RESET = 1'b0;
        #1;
        checks += 5;
        if (SCLK !== 1'b1)       begin $display("FAIL reset_sclk got %b want 1", SCLK); errors++; end
        if (SDAT_OE !== 1'b0)    begin $display("FAIL reset_oe got %b want 0", SDAT_OE); errors++; end
        if (END !== 1'b0)        begin $display("FAIL reset_end got %b want 0", END); errors++; end
        if (ACK !== 3'b000)      begin $display("FAIL reset_ack got %b want 000", ACK); errors++; end
        if (ACK_ERR !== 1'b0)    begin $display("FAIL reset_ackerr got %b want 0", ACK_ERR); errors++; end
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        mon_clr = 1'b0;
        repeat (2) @(negedge CLOCK);
    endtask

    task automatic test_basic();
        int cyc, p0, s0;
        logic [7:0] e, g;
        p0 = pulses; s0 = stops;
        exp_q.push_back(WM8731_ADDR_W); exp_q.push_back(8'h0C); exp_q.push_back(8'h00);
        do_xfer(24'h340C00, 3'b111, 1'b0, cyc);
        repeat (2) @(negedge CLOCK);
        checks += 5;
        if (cyc !== XFER_CYC)      begin $display("FAIL basic_latency got %0d want %0d", cyc, XFER_CYC); errors++; end
        if (ACK !== 3'b111)        begin $display("FAIL basic_ack got %b want 111", ACK); errors++; end
        if (ACK_ERR !== 1'b0)      begin $display("FAIL basic_ackerr got %b want 0", ACK_ERR); errors++; end
        if (pulses - p0 !== 27)    begin $display("FAIL basic_pulses got %0d want 27", pulses - p0); errors++; end
        if (stops - s0 !== 1)      begin $display("FAIL basic_stops got %0d want 1", stops - s0); errors++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 8'hxx;
            if (got_q.size() > 0) g = got_q.pop_front();
            checks++;
            if (g !== e) begin $display("FAIL basic_byte got %h want %h", g, e); errors++; end
        end
    endtask

    task automatic test_go_held_reset();
        int cyc, r0;
        logic [7:0] e, g;
        @(negedge CLOCK);
        mon_clr = 1'b1;
        RESET = 1'b0;
        GO = 1'b1;
        DATA = 24'h341201;
        ack_mask = 3'b111;
        repeat (3) @(negedge CLOCK);
        mon_clr = 1'b0;
        r0 = end_rises;
        exp_q.push_back(8'h34); exp_q.push_back(8'h12); exp_q.push_back(8'h01);
        RESET = 1'b1;
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge CLOCK);
            #1;
            cyc++;
            if (END === 1'b1) break;
        end
        repeat (600) @(negedge CLOCK);
        checks += 4;
        if (cyc !== XFER_CYC)         begin $display("FAIL held_latency got %0d want %0d", cyc, XFER_CYC); errors++; end
        if (end_rises - r0 !== 1)     begin $display("FAIL held_end_rises got %0d want 1", end_rises - r0); errors++; end
        if (END !== 1'b1)             begin $display("FAIL held_end_level got %b want 1", END); errors++; end
        if (ACK !== 3'b111)           begin $display("FAIL held_ack got %b want 111", ACK); errors++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 8'hxx;
            if (got_q.size() > 0) g = got_q.pop_front();
            checks++;
            if (g !== e) begin $display("FAIL held_byte got %h want %h", g, e); errors++; end
        end
        checks++;
        if (got_q.size() != 0) begin $display("FAIL held_extra_bytes got %0d want 0", got_q.size()); errors++; end
    endtask

    task automatic test_nack();
        int cyc;
        logic [7:0] e, g;
        exp_q.push_back(8'h34); exp_q.push_back(8'h0E);
`ifdef I2C_CFG_NACK_ABORT_EN
        do_xfer(24'h340E5B, 3'b101, 1'b0, cyc);
        repeat (2) @(negedge CLOCK);
        checks += 2;
        if (cyc !== ABRT_CYC)   begin $display("FAIL nack_latency got %0d want %0d", cyc, ABRT_CYC); errors++; end
        if (ACK !== 3'b100)     begin $display("FAIL nack_ack got %b want 100", ACK); errors++; end
`else
        exp_q.push_back(8'h5B);
        do_xfer(24'h340E5B, 3'b101, 1'b0, cyc);
        repeat (2) @(negedge CLOCK);
        checks += 2;
        if (cyc !== XFER_CYC)   begin $display("FAIL nack_latency got %0d want %0d", cyc, XFER_CYC); errors++; end
        if (ACK !== 3'b101)     begin $display("FAIL nack_ack got %b want 101", ACK); errors++; end
`endif
        checks++;
        if (ACK_ERR !== 1'b1)   begin $display("FAIL nack_ackerr got %b want 1", ACK_ERR); errors++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 8'hxx;
            if (got_q.size() > 0) g = got_q.pop_front();
            checks++;
            if (g !== e) begin $display("FAIL nack_byte got %h want %h", g, e); errors++; end
        end
        checks++;
        if (got_q.size() != 0) begin $display("FAIL nack_extra_bytes got %0d want 0", got_q.size()); errors++; end
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [7:0] e, g;
        @(negedge CLOCK);
        GO = 1'b0;
        repeat (2) @(negedge CLOCK);
        DATA = 24'h3400FF;
        ack_mask = 3'b111;
        GO = 1'b1;
        repeat (40 * DIV) @(posedge CLOCK);
        @(negedge CLOCK);
        mon_clr = 1'b1;
        RESET = 1'b0;
        #1;
        checks += 4;
        if (SCLK !== 1'b1)    begin $display("FAIL mid_reset_sclk got %b want 1", SCLK); errors++; end
        if (SDAT_OE !== 1'b0) begin $display("FAIL mid_reset_oe got %b want 0", SDAT_OE); errors++; end
        if (END !== 1'b0)     begin $display("FAIL mid_reset_end got %b want 0", END); errors++; end
        if (ACK !== 3'b000)   begin $display("FAIL mid_reset_ack got %b want 000", ACK); errors++; end
        GO = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK);
        mon_clr = 1'b0;
        exp_q.push_back(8'h34); exp_q.push_back(8'h1A); exp_q.push_back(8'h2B);
        do_xfer(24'h341A2B, 3'b111, 1'b0, cyc);
        repeat (2) @(negedge CLOCK);
        checks += 2;
        if (cyc !== XFER_CYC) begin $display("FAIL mid_after_latency got %0d want %0d", cyc, XFER_CYC); errors++; end
        if (ACK !== 3'b111)   begin $display("FAIL mid_after_ack got %b want 111", ACK); errors++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 8'hxx;
            if (got_q.size() > 0) g = got_q.pop_front();
            checks++;
            if (g !== e) begin $display("FAIL mid_after_byte got %h want %h", g, e); errors++; end
        end
    endtask

    task automatic test_go_toggle();
        int cyc, r0;
        logic [7:0] e, g;
        r0 = end_rises;
        exp_q.push_back(8'h34); exp_q.push_back(8'hAA); exp_q.push_back(8'h55);
        do_xfer(24'h34AA55, 3'b111, 1'b1, cyc);
        repeat (40) @(negedge CLOCK);
        checks += 3;
        if (cyc !== XFER_CYC)     begin $display("FAIL toggle_latency got %0d want %0d", cyc, XFER_CYC); errors++; end
        if (end_rises - r0 !== 1) begin $display("FAIL toggle_end_rises got %0d want 1", end_rises - r0); errors++; end
        if (END !== 1'b1)         begin $display("FAIL toggle_end_level got %b want 1", END); errors++; end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = 8'hxx;
            if (got_q.size() > 0) g = got_q.pop_front();
            checks++;
            if (g !== e) begin $display("FAIL toggle_byte got %h want %h", g, e); errors++; end
        end
        checks++;
        if (got_q.size() != 0) begin $display("FAIL toggle_extra_bytes got %0d want 0", got_q.size()); errors++; end
    endtask

    task automatic test_back_to_back();
        logic [23:0] rom [9];
        int cyc, r0, s0;
        logic [7:0] e, g;
        rom = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                24'h340812, 24'h340A06, 24'h340C00, 24'h341201};
        r0 = end_rises; s0 = stops;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(rom[i][23:16]);
            exp_q.push_back(rom[i][15:8]);
            exp_q.push_back(rom[i][7:0]);
            do_xfer(rom[i], 3'b111, 1'b0, cyc);
            checks++;
            if (cyc !== XFER_CYC) begin $display("FAIL b2b_latency[%0d] got %0d want %0d", i, cyc, XFER_CYC); errors++; end
            @(negedge CLOCK);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = 8'hxx;
                if (got_q.size() > 0) g = got_q.pop_front();
                checks++;
                if (g !== e) begin $display("FAIL b2b_byte[%0d] got %h want %h", i, g, e); errors++; end
            end
        end
        repeat (4) @(negedge CLOCK);
        checks += 3;
        if (end_rises - r0 !== 9) begin $display("FAIL b2b_end_rises got %0d want 9", end_rises - r0); errors++; end
        if (stops - s0 !== 9)     begin $display("FAIL b2b_stops got %0d want 9", stops - s0); errors++; end
        if (proto_err !== 0)      begin $display("FAIL b2b_protocol got %0d want 0", proto_err); errors++; end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_go_held_reset();
        test_nack();
        test_reset_mid();
        test_go_toggle();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
